multirate_sequencer: RTL

- Control and sequencing block for the L=2 interpolate / FIR / M=2 decimate bandpass datapath.
- Accepts low-rate input samples over a valid/ready handshake and generates the high-rate slot stream for the filter: data sample on phase 0, zero-stuff on other phases.
- Masks the filter's start-up transient, decimates the result stream, presents outputs over a valid/ready handshake, and flushes the delay line on stop.

---
 rtl/multirate_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/multirate_sequencer.sv
// rtl/multirate_sequencer.sv - slot sequencer for the L-interpolate / FIR / M-decimate bandpass path
module multirate_sequencer #(
    parameter int WIDTH = 8,
    parameter int L     = 2,
    parameter int M     = 2,
    parameter int FILL  = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             dp_clr,
    output logic             dp_en,
    output logic [WIDTH-1:0] dp_sample,
    input  logic [WIDTH-1:0] dp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);
    localparam int PW = (L > 1) ? $clog2(L) : 1;
    localparam int DW = (M > 1) ? $clog2(M) : 1;
    localparam int FW = (FILL > 0) ? $clog2(FILL + 1) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(L - 1);
    localparam logic [DW-1:0] DEC_LAST   = DW'(M - 1);
    localparam logic [FW-1:0] FILL_N     = FW'(FILL);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [DW-1:0]    dec_q, dec_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic             pend_keep_q, pend_keep_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             dp_clr_q, dp_clr_d;

    logic active, flushing, phase0, src_ok, slot_left, go, keep;

    always_comb begin
        active    = (state_q != S_IDLE);
        flushing  = (state_q == S_FLUSH);
        phase0    = (phase_q == '0);
        src_ok    = (phase0 && !flushing) ? in_valid : 1'b1;
        slot_left = !flushing || (flush_q != FILL_N);
        // The capture cycle (pend_keep) blocks issue so a result never overwrites an unsent one.
        go        = active && slot_left && src_ok && (!out_valid_q || out_ready) && !pend_keep_q;
        keep      = go && (dec_q == '0) && ((fill_q == FILL_N) || flushing);

        state_d     = state_q;
        phase_d     = phase_q;
        dec_d       = dec_q;
        fill_d      = fill_q;
        flush_d     = flush_q;
        pend_keep_d = keep;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        dp_clr_d    = 1'b0;

        if (go) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
            dec_d   = (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
            if (fill_q != FILL_N) begin
                fill_d = fill_q + 1'b1;
            end
            if (flushing) begin
                flush_d = flush_q + 1'b1;
            end
        end

        if (pend_keep_q) begin
            out_valid_d = 1'b1;
            data_out_d  = dp_result;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FILL;
                    dp_clr_d    = 1'b1;
                    phase_d     = '0;
                    dec_d       = '0;
                    fill_d      = '0;
                    flush_d     = '0;
                    pend_keep_d = 1'b0;
                end
            end
            S_FILL: begin
                if (stop) begin
                    state_d = S_FLUSH;
                end else if (fill_d == FILL_N) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if ((flush_q == FILL_N) && !pend_keep_q && !out_valid_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            dec_q       <= '0;
            fill_q      <= '0;
            flush_q     <= '0;
            pend_keep_q <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            dp_clr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            dec_q       <= dec_d;
            fill_q      <= fill_d;
            flush_q     <= flush_d;
            pend_keep_q <= pend_keep_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            dp_clr_q    <= dp_clr_d;
        end
    end

    assign in_ready  = go && phase0 && !flushing;
    assign dp_en     = go;
    assign dp_sample = (active && !flushing && phase0) ? data_in : '0;
    assign dp_clr    = dp_clr_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign busy      = active;

endmodule
